sevenseg_capture: RTL and testbench



---
 rtl/sevenseg_pkg.sv | 23 ++
 rtl/sevenseg_glyph_lookup.sv | 22 ++
 rtl/sevenseg_capture.sv | 188 ++++++++++++++++++
 tb/tb_sevenseg_capture.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: active-low glyphs (dp off) used by the display
// encoder and by the capture block, plus the capture FSM state type.
package sevenseg_pkg;

    // Element k is the active-low pattern for hex nibble k; bit 0 is the decimal point.
    localparam logic [15:0][7:0] SEG_GLYPHS = {
        8'h71, 8'h61, 8'h85, 8'hE5, 8'hC1, 8'h11, 8'h19, 8'h01,
        8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        CAP_IDLE   = 2'd0,
        CAP_FILTER = 2'd1,
        CAP_HOLD   = 2'd2
    } cap_state_e;

    function automatic logic [7:0] glyphOf(input logic [3:0] nibble);
        return SEG_GLYPHS[nibble];
    endfunction

endpackage

// File: rtl/sevenseg_glyph_lookup.sv
// Inverse glyph table: maps the seven active-low segment lines back to a hex nibble.
module sevenseg_glyph_lookup
    import sevenseg_pkg::*;
(
    input  logic [6:0] i_segN,
    output logic       o_match,
    output logic [3:0] o_nibble
);

    // Glyphs are unique, so at most one entry can hit; the decimal point is not compared.
    always_comb begin
        o_match  = 1'b0;
        o_nibble = 4'h0;
        for (int k = 0; k < 16; k++) begin
            if (i_segN == SEG_GLYPHS[k][7:1]) begin
                o_match  = 1'b1;
                o_nibble = 4'(k);
            end
        end
    end

endmodule

// File: rtl/sevenseg_capture.sv
// Reads back a multiplexed seven-segment display bus: debounces each scanned digit,
// decodes it to hex and publishes complete frames with per-digit dp/error flags.
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic [7:0]              seg_n,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   err,
    output logic                    frame_valid,
    output logic                    stall
);

    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SAMPLE_W = NUM_DIGITS + 8;

    cap_state_e r_state;
    cap_state_e w_stateNext;

    logic [SAMPLE_W-1:0]             w_sampleNext;
    logic [SAMPLE_W-1:0]             r_sample;
    logic                            w_valid;
    logic                            w_same;
    logic [IDX_W-1:0]                w_digitIdx;
    logic [CNT_W-1:0]                r_cnt;
    logic [CNT_W-1:0]                w_cntNext;
    logic                            w_commit;
    logic                            w_lookMatch;
    logic [3:0]                      w_lookNib;

    logic [NUM_DIGITS-1:0][3:0]      r_workNib;
    logic [NUM_DIGITS-1:0]           r_workDp;
    logic [NUM_DIGITS-1:0]           r_workErr;
    logic [NUM_DIGITS-1:0][3:0]      w_mergedNib;
    logic [NUM_DIGITS-1:0]           w_mergedDp;
    logic [NUM_DIGITS-1:0]           w_mergedErr;
    logic [NUM_DIGITS-1:0]           r_seen;
    logic [NUM_DIGITS-1:0]           w_seenNext;
    logic                            w_frameDone;

    logic [TO_W-1:0]                 r_toCnt;
    logic                            w_timeout;

    logic [NUM_DIGITS-1:0][3:0]      r_value;
    logic [NUM_DIGITS-1:0]           r_dp;
    logic [NUM_DIGITS-1:0]           r_err;
    logic                            r_frameValid;
    logic                            r_stall;

    // The FSM judges the pair being loaded into S against the pair S currently holds,
    // so the first capture edge already counts as one stable sample.
    assign w_sampleNext = {an_n, seg_n};
    assign w_valid      = ($countones(~an_n) == 1);
    assign w_same       = (w_sampleNext == r_sample);

    always_comb begin
        w_digitIdx = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (!an_n[d]) begin
                w_digitIdx = IDX_W'(d);
            end
        end
    end

    sevenseg_glyph_lookup u_lookup (
        .i_segN   (seg_n[7:1]),
        .o_match  (w_lookMatch),
        .o_nibble (w_lookNib)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= CAP_IDLE;
            r_cnt    <= '0;
            r_sample <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_cnt    <= w_cntNext;
            r_sample <= w_sampleNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            CAP_IDLE: begin
                if (w_valid) begin
                    w_stateNext = CAP_FILTER;
                    w_cntNext   = CNT_W'(1);
                end
            end
            CAP_FILTER: begin
                if (!w_same) begin
                    w_stateNext = w_valid ? CAP_FILTER : CAP_IDLE;
                    w_cntNext   = w_valid ? CNT_W'(1) : '0;
                end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                    w_commit    = 1'b1;
                    w_stateNext = CAP_HOLD;
                    w_cntNext   = CNT_W'(STABLE_CYCLES);
                end else begin
                    w_cntNext   = r_cnt + 1'b1;
                end
            end
            CAP_HOLD: begin
                if (!w_same) begin
                    w_stateNext = w_valid ? CAP_FILTER : CAP_IDLE;
                    w_cntNext   = w_valid ? CNT_W'(1) : '0;
                end
            end
            default: begin
                w_stateNext = CAP_IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    // Working store with the digit being committed merged in, so a completing
    // commit can publish the full frame on the same edge.
    always_comb begin
        w_mergedNib              = r_workNib;
        w_mergedDp               = r_workDp;
        w_mergedErr              = r_workErr;
        w_mergedNib[w_digitIdx]  = w_lookMatch ? w_lookNib : 4'h0;
        w_mergedDp[w_digitIdx]   = ~seg_n[0];
        w_mergedErr[w_digitIdx]  = ~w_lookMatch;
    end

    assign w_seenNext  = r_seen | (NUM_DIGITS'(1) << w_digitIdx);
    assign w_frameDone = w_commit && (&w_seenNext);
    assign w_timeout   = (r_toCnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_workNib    <= '0;
            r_workDp     <= '0;
            r_workErr    <= '0;
            r_seen       <= '0;
            r_toCnt      <= '0;
            r_value      <= '0;
            r_dp         <= '0;
            r_err        <= '0;
            r_frameValid <= 1'b0;
            r_stall      <= 1'b0;
        end else begin
            r_frameValid <= 1'b0;
            if (w_commit) begin
                r_workNib <= w_mergedNib;
                r_workDp  <= w_mergedDp;
                r_workErr <= w_mergedErr;
                r_toCnt   <= '0;
                if (w_frameDone) begin
                    r_value      <= w_mergedNib;
                    r_dp         <= w_mergedDp;
                    r_err        <= w_mergedErr;
                    r_seen       <= '0;
                    r_frameValid <= 1'b1;
                    r_stall      <= 1'b0;
                end else begin
                    r_seen <= w_seenNext;
                end
            end else if (w_timeout) begin
                r_seen  <= '0;
                r_stall <= 1'b1;
                r_toCnt <= '0;
            end else begin
                r_toCnt <= r_toCnt + 1'b1;
            end
        end
    end

    assign value       = r_value;
    assign dp          = r_dp;
    assign err         = r_err;
    assign frame_valid = r_frameValid;
    assign stall       = r_stall;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture: scans hand-built frames onto the display bus
// and compares the published frames against hand-computed values.
module tb_sevenseg_capture;

    localparam int NUM_DIGITS = 8;
    localparam int STABLE     = 4;
    localparam int TIMEOUT    = 65536;

    logic        clk;
    logic        rst;
    logic [7:0]  an_n;
    logic [7:0]  seg_n;
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  err;
    logic        frame_valid;
    logic        stall;

    int checks;
    int errors;
    int frameCount;
    int f0;

    logic [7:0] tbGlyph [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h19, 8'h11, 8'hC1, 8'hE5, 8'h85, 8'h61, 8'h71};

    sevenseg_capture #(
        .NUM_DIGITS     (NUM_DIGITS),
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .value       (value),
        .dp          (dp),
        .err         (err),
        .frame_valid (frame_valid),
        .stall       (stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame pulses are counted on the falling edge, so a pulse longer than one
    // cycle shows up as extra frames.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) frameCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int digit, input logic [7:0] seg, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            an_n  = ~(8'(1) << digit);
            seg_n = seg;
        end
    endtask

    task automatic idleBus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            an_n  = 8'hFF;
            seg_n = 8'hFF;
        end
    endtask

    // Scans digits firstD..lastD of val for 8 cycles each; blankD shows 8'h7F, and a
    // glitch of digit 1 showing F for glitchLen cycles follows digit 2.
    task automatic scanRange(input logic [31:0] val, input logic [7:0] dpMask,
                             input int firstD, input int lastD, input int blankD, input int glitchLen);
        logic [7:0] seg;
        for (int d = firstD; d <= lastD; d++) begin
            seg = tbGlyph[val[4*d +: 4]];
            if (dpMask[d]) seg[0] = 1'b0;
            if (d == blankD) seg = 8'h7F;
            applyStimulus(d, seg, 8);
            if (d == 2 && glitchLen > 0) applyStimulus(1, tbGlyph[15], glitchLen);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        frameCount = 0;
        rst        = 1'b1;
        an_n       = 8'hFF;
        seg_n      = 8'hFF;
        repeat (3) @(negedge clk);
        checkOutput("reset_value", value, 32'h0);
        checkOutput("reset_dp", 32'(dp), 32'h0);
        checkOutput("reset_err", 32'(err), 32'h0);
        checkOutput("reset_frame_valid", 32'(frame_valid), 32'h0);
        checkOutput("reset_stall", 32'(stall), 32'h0);
        rst = 1'b0;

        f0 = frameCount;
        scanRange(32'h76543210, 8'h00, 0, 7, -1, 0);
        idleBus(3);
        checkOutput("clean_value", value, 32'h76543210);
        checkOutput("clean_dp", 32'(dp), 32'h0);
        checkOutput("clean_err", 32'(err), 32'h0);
        checkOutput("clean_frames", 32'(frameCount - f0), 32'd1);
        checkOutput("clean_stall", 32'(stall), 32'h0);

        f0 = frameCount;
        scanRange(32'h7654C210, 8'h08, 0, 7, -1, 0);
        idleBus(3);
        checkOutput("dp_value", value, 32'h7654C210);
        checkOutput("dp_dp", 32'(dp), 32'h08);
        checkOutput("dp_frames", 32'(frameCount - f0), 32'd1);

        f0 = frameCount;
        scanRange(32'h01234567, 8'h00, 0, 7, -1, STABLE - 1);
        idleBus(3);
        checkOutput("glitch3_value", value, 32'h01234567);
        checkOutput("glitch3_dp", 32'(dp), 32'h0);
        checkOutput("glitch3_frames", 32'(frameCount - f0), 32'd1);

        f0 = frameCount;
        scanRange(32'h01234567, 8'h00, 0, 7, -1, STABLE);
        idleBus(3);
        checkOutput("glitch4_value", value, 32'h012345F7);
        checkOutput("glitch4_frames", 32'(frameCount - f0), 32'd1);

        f0 = frameCount;
        scanRange(32'h89ABCDEF, 8'h00, 0, 6, -1, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            an_n  = 8'hFC;
            seg_n = tbGlyph[0];
        end
        idleBus(3);
        checkOutput("multi_anode_frames", 32'(frameCount - f0), 32'd0);
        checkOutput("multi_anode_value", value, 32'h012345F7);
        scanRange(32'h89ABCDEF, 8'h00, 7, 7, -1, 0);
        idleBus(3);
        checkOutput("after_multi_value", value, 32'h89ABCDEF);
        checkOutput("after_multi_frames", 32'(frameCount - f0), 32'd1);

        f0 = frameCount;
        scanRange(32'h76543210, 8'h00, 0, 7, 5, 0);
        idleBus(3);
        checkOutput("blank_value", value, 32'h76043210);
        checkOutput("blank_err", 32'(err), 32'h20);
        checkOutput("blank_dp", 32'(dp), 32'h0);
        checkOutput("blank_frames", 32'(frameCount - f0), 32'd1);

        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("async_reset_value", value, 32'h0);
        checkOutput("async_reset_err", 32'(err), 32'h0);
        checkOutput("async_reset_dp", 32'(dp), 32'h0);
        checkOutput("async_reset_stall", 32'(stall), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        f0 = frameCount;
        idleBus(1000);
        checkOutput("idle_frames", 32'(frameCount - f0), 32'd0);
        checkOutput("idle_value", value, 32'h0);
        checkOutput("idle_stall", 32'(stall), 32'h0);

        f0 = frameCount;
        scanRange(32'hFEDCBA98, 8'h00, 0, 7, -1, 0);
        idleBus(3);
        checkOutput("frameA_value", value, 32'hFEDCBA98);
        checkOutput("frameA_frames", 32'(frameCount - f0), 32'd1);

        f0 = frameCount;
        scanRange(32'h11112222, 8'h00, 0, 3, -1, 0);
        idleBus(TIMEOUT - 10);
        checkOutput("pre_timeout_stall", 32'(stall), 32'h0);
        idleBus(15);
        checkOutput("timeout_stall", 32'(stall), 32'h1);
        checkOutput("timeout_value", value, 32'hFEDCBA98);
        checkOutput("timeout_frames", 32'(frameCount - f0), 32'd0);

        f0 = frameCount;
        scanRange(32'h13579BDF, 8'h00, 0, 7, -1, 0);
        idleBus(3);
        checkOutput("recover_value", value, 32'h13579BDF);
        checkOutput("recover_stall", 32'(stall), 32'h0);
        checkOutput("recover_frames", 32'(frameCount - f0), 32'd1);

        scanRange(32'h2468ACE0, 8'h00, 0, 5, -1, 0);
        @(negedge clk);
        an_n  = 8'hFF;
        seg_n = 8'hFF;
        rst   = 1'b1;
        #2;
        rst   = 1'b0;
        f0 = frameCount;
        scanRange(32'h2468ACE0, 8'h00, 6, 7, -1, 0);
        idleBus(3);
        checkOutput("partial_frames", 32'(frameCount - f0), 32'd0);
        checkOutput("partial_value", value, 32'h0);
        scanRange(32'h2468ACE0, 8'h00, 0, 5, -1, 0);
        idleBus(3);
        checkOutput("rescan_frames", 32'(frameCount - f0), 32'd1);
        checkOutput("rescan_value", value, 32'h2468ACE0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
